// File: rtl/clock_pkg.sv
// Shared definitions for the clock-setting blocks: editor FSM states, BCD field width
// and hour-format conversion helpers.
package clock_pkg;

    localparam int BCD_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EDIT = 2'd2
    } state_t;

    function automatic logic [6:0] bcd2bin(input logic [BCD_W-1:0] v);
        return 7'(v[7:4]) * 7'd10 + 7'(v[3:0]);
    endfunction

    function automatic logic [BCD_W-1:0] bin2bcd(input logic [6:0] b);
        return {4'(b / 7'd10), 4'(b % 7'd10)};
    endfunction

    // 24 h hour -> {pm, 12 h hour}
    function automatic logic [BCD_W:0] hour_to12(input logic [BCD_W-1:0] h);
        logic [6:0] b;
        b = bcd2bin(h);
        if (b == 7'd0)       return {1'b0, 8'h12};
        else if (b < 7'd12)  return {1'b0, bin2bcd(b)};
        else if (b == 7'd12) return {1'b1, 8'h12};
        else                 return {1'b1, bin2bcd(b - 7'd12)};
    endfunction

    // 12 h hour plus pm flag -> 24 h hour
    function automatic logic [BCD_W-1:0] hour_to24(input logic [BCD_W-1:0] h, input logic pm);
        logic [6:0] b;
        b = bcd2bin(h);
        if (pm) return (b == 7'd12) ? 8'h12 : bin2bcd(b + 7'd12);
        else    return (b == 7'd12) ? 8'h00 : h;
    endfunction

endpackage

// File: rtl/bcd2_step.sv
// Combinational one-step increment/decrement of a 2-digit BCD value with min/max wrap.
module bcd2_step
    import clock_pkg::*;
(
    input  logic [BCD_W-1:0] i_value,
    input  logic [BCD_W-1:0] i_min,
    input  logic [BCD_W-1:0] i_max,
    input  logic             i_up,
    output logic [BCD_W-1:0] o_result
);

    always_comb begin
        o_result = i_value;
        if (i_up) begin
            if (i_value >= i_max)
                o_result = i_min;
            else if (i_value[3:0] >= 4'd9)
                o_result = {i_value[7:4] + 4'd1, 4'd0};
            else
                o_result = {i_value[7:4], i_value[3:0] + 4'd1};
        end else begin
            // Values below min (e.g. 00 hours in 12 h mode) also wrap to max.
            if (i_value <= i_min)
                o_result = i_max;
            else if (i_value[3:0] == 4'd0)
                o_result = {i_value[7:4] - 4'd1, 4'd9};
            else
                o_result = {i_value[7:4], i_value[3:0] - 4'd1};
        end
    end

endmodule

// File: rtl/bcd_field_editor.sv
// Button-driven editor for a multi-field BCD value (e.g. hh:mm:ss) with cursor,
// auto-repeat and 12/24 h handling of one hour field.
module bcd_field_editor
    import clock_pkg::*;
#(
    parameter int                        NUM_FIELDS = 3,
    parameter logic [8*NUM_FIELDS-1:0]   FIELD_MAX  = {8'h59, 8'h59, 8'h23},
    parameter int                        HOUR_FIELD = 0,
    parameter logic [23:0]               RPT_DELAY  = 24'd50_000_000,
    parameter logic [23:0]               RPT_PERIOD = 24'd10_000_000,
    localparam int                       CW         = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      up,
    input  logic                      down,
    input  logic                      left,
    input  logic                      right,
    input  logic                      fmt12,
    input  logic                      ampm_in,
    input  logic [8*NUM_FIELDS-1:0]   data_in,
    output logic [8*NUM_FIELDS-1:0]   data_out,
    output logic                      ampm_out,
    output logic [CW-1:0]             cursor,
    output logic                      commit
);

    localparam bit            HOUR_EN  = (HOUR_FIELD < NUM_FIELDS);
    localparam int            HOUR_POS = HOUR_EN ? HOUR_FIELD : 0;
    localparam logic [CW-1:0] HOUR_IDX = CW'(HOUR_POS);
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_FIELDS - 1);

    state_t                    r_state, w_state_next;
    logic [8*NUM_FIELDS-1:0]   r_data, w_data_next;
    logic                      r_ampm, w_ampm_next;
    logic [CW-1:0]             r_cursor, w_cursor_next;
    logic                      r_fmt, w_fmt_next;
    logic                      r_commit, w_commit_next;
    logic                      r_prev_up, r_prev_down, r_prev_left, r_prev_right;
    logic [23:0]               r_rpt_cnt;
    logic                      r_rpt_run;

    logic [BCD_W-1:0] w_fields [NUM_FIELDS];
    logic [BCD_W-1:0] w_fmax   [NUM_FIELDS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
            assign w_fields[gi] = r_data[8*gi +: 8];
            assign w_fmax[gi]   = FIELD_MAX[8*gi +: 8];
        end
    endgenerate

    logic w_up_rise, w_down_rise, w_left_rise, w_right_rise;
    assign w_up_rise    = up    & ~r_prev_up;
    assign w_down_rise  = down  & ~r_prev_down;
    assign w_left_rise  = left  & ~r_prev_left;
    assign w_right_rise = right & ~r_prev_right;

    // Auto-repeat: first extra step RPT_DELAY cycles after the edge, then every RPT_PERIOD.
    logic        w_hold_one, w_rpt_fire;
    logic [23:0] w_rpt_target;
    assign w_hold_one   = (r_state == ST_EDIT) && (up ^ down);
    assign w_rpt_target = r_rpt_run ? RPT_PERIOD : RPT_DELAY;
    assign w_rpt_fire   = w_hold_one && (r_rpt_cnt == w_rpt_target);

    logic w_step_up, w_step_dn;
    assign w_step_up = (w_up_rise & ~w_down_rise) | (w_rpt_fire & up);
    assign w_step_dn = (w_down_rise & ~w_up_rise) | (w_rpt_fire & down);

    logic [BCD_W-1:0] w_sel, w_min, w_max, w_stepped, w_new_field;
    logic             w_is_hour, w_clamp, w_toggle;
    assign w_sel     = w_fields[r_cursor];
    assign w_is_hour = HOUR_EN && (r_cursor == HOUR_IDX);
    assign w_min     = (w_is_hour && r_fmt) ? 8'h01 : 8'h00;
    assign w_max     = (w_is_hour && r_fmt) ? 8'h12 : w_fmax[r_cursor];
    assign w_clamp   = (w_sel > w_max);

    bcd2_step u_step (
        .i_value  (w_sel),
        .i_min    (w_min),
        .i_max    (w_max),
        .i_up     (w_step_up),
        .o_result (w_stepped)
    );

    assign w_new_field = w_clamp ? w_max : w_stepped;
    assign w_toggle    = w_is_hour && r_fmt && !w_clamp &&
                         ((w_step_up && w_sel == 8'h11) || (w_step_dn && w_sel == 8'h12));

    logic             w_fmt_change;
    logic [BCD_W:0]   w_h12;
    logic [BCD_W-1:0] w_h24;
    assign w_fmt_change = HOUR_EN && (fmt12 != r_fmt);
    assign w_h12        = hour_to12(w_fields[HOUR_POS]);
    assign w_h24        = hour_to24(w_fields[HOUR_POS], r_ampm);

    always_comb begin
        w_state_next  = r_state;
        w_data_next   = r_data;
        w_ampm_next   = r_ampm;
        w_cursor_next = r_cursor;
        w_fmt_next    = r_fmt;
        w_commit_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (en) w_state_next = ST_LOAD;
            end
            ST_LOAD: begin
                w_data_next   = data_in;
                w_ampm_next   = ampm_in;
                w_cursor_next = '0;
                w_fmt_next    = fmt12;
                if (en) begin
                    w_state_next = ST_EDIT;
                end else begin
                    w_state_next  = ST_IDLE;
                    w_commit_next = 1'b1;
                end
            end
            ST_EDIT: begin
                if (!en) begin
                    w_state_next  = ST_IDLE;
                    w_commit_next = 1'b1;
                end else if (w_fmt_change) begin
                    // Format switch takes the cycle; buttons are not acted on this cycle.
                    w_fmt_next = fmt12;
                    if (fmt12) begin
                        w_data_next[8*HOUR_POS +: 8] = w_h12[BCD_W-1:0];
                        w_ampm_next                  = w_h12[BCD_W];
                    end else begin
                        w_data_next[8*HOUR_POS +: 8] = w_h24;
                    end
                end else begin
                    if (w_step_up || w_step_dn) begin
                        for (int i = 0; i < NUM_FIELDS; i++)
                            if (r_cursor == CW'(i)) w_data_next[8*i +: 8] = w_new_field;
                        if (w_toggle) w_ampm_next = ~r_ampm;
                    end
                    if (w_right_rise && !w_left_rise)
                        w_cursor_next = (r_cursor == LAST_IDX) ? '0 : r_cursor + 1'b1;
                    else if (w_left_rise && !w_right_rise)
                        w_cursor_next = (r_cursor == '0) ? LAST_IDX : r_cursor - 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_data       <= '0;
            r_ampm       <= 1'b0;
            r_cursor     <= '0;
            r_fmt        <= 1'b0;
            r_commit     <= 1'b0;
            r_prev_up    <= 1'b0;
            r_prev_down  <= 1'b0;
            r_prev_left  <= 1'b0;
            r_prev_right <= 1'b0;
            r_rpt_cnt    <= '0;
            r_rpt_run    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_data       <= w_data_next;
            r_ampm       <= w_ampm_next;
            r_cursor     <= w_cursor_next;
            r_fmt        <= w_fmt_next;
            r_commit     <= w_commit_next;
            r_prev_up    <= up;
            r_prev_down  <= down;
            r_prev_left  <= left;
            r_prev_right <= right;
            if (!w_hold_one) begin
                r_rpt_cnt <= '0;
                r_rpt_run <= 1'b0;
            end else if (w_rpt_fire) begin
                r_rpt_cnt <= 24'd1;
                r_rpt_run <= 1'b1;
            end else begin
                r_rpt_cnt <= r_rpt_cnt + 24'd1;
            end
        end
    end

    assign data_out = r_data;
    assign ampm_out = r_ampm;
    assign cursor   = r_cursor;
    assign commit   = r_commit;

endmodule

// File: tb/tb_bcd_field_editor.sv
// Scoreboard bench for bcd_field_editor: expected outputs are queued when stimulus is
// driven and compared one cycle later, when the editor has acted on it.
module tb_bcd_field_editor;

    localparam logic [23:0] D = 24'd10;
    localparam logic [23:0] P = 24'd4;

    logic        clk = 1'b0;
    logic        reset, en, up, down, left, right, fmt12, ampm_in;
    logic [23:0] data_in, data_out;
    logic        ampm_out, commit;
    logic [1:0]  cursor;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [23:0] data;
        logic        ampm;
        logic [1:0]  cur;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];

    bcd_field_editor #(
        .NUM_FIELDS (3),
        .FIELD_MAX  ({8'h59, 8'h59, 8'h23}),
        .HOUR_FIELD (0),
        .RPT_DELAY  (D),
        .RPT_PERIOD (P)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up       (up),
        .down     (down),
        .left     (left),
        .right    (right),
        .fmt12    (fmt12),
        .ampm_in  (ampm_in),
        .data_in  (data_in),
        .data_out (data_out),
        .ampm_out (ampm_out),
        .cursor   (cursor),
        .commit   (commit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [23:0] d, input logic a, input logic [1:0] c);
        exp_t e;
        e.data = d;
        e.ampm = a;
        e.cur  = c;
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic sb_check();
        exp_t  e;
        string t;
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        $display("[TB] %s: data=%06h ampm=%0d cursor=%0d (exp %06h %0d %0d)",
                 t, data_out, ampm_out, cursor, e.data, e.ampm, e.cur);
        check({t, ".data"},   32'(data_out), 32'(e.data));
        check({t, ".ampm"},   32'(ampm_out), 32'(e.ampm));
        check({t, ".cursor"}, 32'(cursor),   32'(e.cur));
    endtask

    task automatic press(input string tag, input logic u, input logic d, input logic l, input logic r,
                         input logic [23:0] ed, input logic ea, input logic [1:0] ec);
        @(negedge clk);
        up = u; down = d; left = l; right = r;
        sb_push(tag, ed, ea, ec);
        @(negedge clk);
        up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
        sb_check();
    endtask

    task automatic start_session(input string tag, input logic [23:0] din, input logic f, input logic ap);
        @(negedge clk);
        data_in = din; fmt12 = f; ampm_in = ap; en = 1'b1;
        sb_push(tag, din, ap, 2'd0);
        repeat (2) @(negedge clk);
        sb_check();
    endtask

    task automatic end_session(input string tag, input logic [23:0] ed, input logic ea, input logic [1:0] ec);
        int pulses;
        pulses = 0;
        @(negedge clk);
        en = 1'b0;
        sb_push(tag, ed, ea, ec);
        repeat (4) begin
            @(negedge clk);
            if (commit) pulses++;
        end
        check({tag, ".commit_pulses"}, 32'(pulses), 32'd1);
        sb_check();
    endtask

    task automatic set_fmt(input string tag, input logic f, input logic [23:0] ed, input logic ea, input logic [1:0] ec);
        @(negedge clk);
        fmt12 = f;
        sb_push(tag, ed, ea, ec);
        @(negedge clk);
        sb_check();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; en = 1'b0; up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
        fmt12 = 1'b0; ampm_in = 1'b0; data_in = '0;
        repeat (3) @(negedge clk);
        sb_push("reset", 24'h000000, 1'b0, 2'd0);
        sb_check();
        check("reset.commit", 32'(commit), 32'd0);
        reset = 1'b0;

        // Hours 23 wrap upward, cursor wrap, simultaneous-button rules.
        start_session("load_235959", 24'h595923, 1'b0, 1'b0);
        press("hour_up_wrap",  1, 0, 0, 0, 24'h595900, 1'b0, 2'd0);
        press("left_wrap",     0, 0, 1, 0, 24'h595900, 1'b0, 2'd2);
        press("right_wrap",    0, 0, 0, 1, 24'h595900, 1'b0, 2'd0);
        press("up_down_both",  1, 1, 0, 0, 24'h595900, 1'b0, 2'd0);
        press("left_right",    0, 0, 1, 1, 24'h595900, 1'b0, 2'd0);
        press("up_and_right",  1, 0, 0, 1, 24'h595901, 1'b0, 2'd1);
        press("min_down",      0, 1, 0, 0, 24'h595801, 1'b0, 2'd1);
        end_session("end1", 24'h595801, 1'b0, 2'd1);

        // 12 h hour field with AM/PM toggling.
        start_session("load_11am", 24'h000011, 1'b1, 1'b0);
        press("h12_up_11_12",  1, 0, 0, 0, 24'h000012, 1'b1, 2'd0);
        press("h12_dn_12_11",  0, 1, 0, 0, 24'h000011, 1'b0, 2'd0);
        press("h12_up_again",  1, 0, 0, 0, 24'h000012, 1'b1, 2'd0);
        press("h12_up_12_01",  1, 0, 0, 0, 24'h000001, 1'b1, 2'd0);
        press("h12_dn_01_12",  0, 1, 0, 0, 24'h000012, 1'b1, 2'd0);
        end_session("end2", 24'h000012, 1'b1, 2'd0);

        // BCD carry and borrow on minutes.
        start_session("load_m09", 24'h000900, 1'b0, 1'b0);
        press("to_minutes",    0, 0, 0, 1, 24'h000900, 1'b0, 2'd1);
        press("m_up_09_10",    1, 0, 0, 0, 24'h001000, 1'b0, 2'd1);
        press("m_dn_10_09",    0, 1, 0, 0, 24'h000900, 1'b0, 2'd1);
        press("m_dn_09_08",    0, 1, 0, 0, 24'h000800, 1'b0, 2'd1);
        end_session("end3", 24'h000800, 1'b0, 2'd1);

        start_session("load_m00", 24'h000000, 1'b0, 1'b0);
        press("to_minutes2",   0, 0, 0, 1, 24'h000000, 1'b0, 2'd1);
        press("m_dn_00_59",    0, 1, 0, 0, 24'h005900, 1'b0, 2'd1);
        end_session("end4", 24'h005900, 1'b0, 2'd1);

        // Format conversion during an edit session.
        start_session("load_h15", 24'h000015, 1'b0, 1'b0);
        set_fmt("fmt_to12",    1'b1, 24'h000003, 1'b1, 2'd0);
        set_fmt("fmt_to24",    1'b0, 24'h000015, 1'b1, 2'd0);
        end_session("end5", 24'h000015, 1'b1, 2'd0);

        // Out-of-range loaded hour clamps to max on the first step.
        start_session("load_h45", 24'h000045, 1'b0, 1'b0);
        press("clamp_up",      1, 0, 0, 0, 24'h000023, 1'b0, 2'd0);
        end_session("end6", 24'h000023, 1'b0, 2'd0);

        // Auto-repeat: edge step plus two repeats.
        start_session("load_rpt", 24'h000000, 1'b0, 1'b0);
        press("to_minutes3",   0, 0, 0, 1, 24'h000000, 1'b0, 2'd1);
        @(negedge clk);
        up = 1'b1;
        sb_push("repeat_hold", 24'h000300, 1'b0, 2'd1);
        repeat (int'(D + 2 * P)) @(negedge clk);
        up = 1'b0;
        sb_check();
        end_session("end7", 24'h000300, 1'b0, 2'd1);

        // Reset in the middle of an edit session.
        start_session("load_mid", 24'h112233, 1'b0, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        sb_push("reset_mid", 24'h000000, 1'b0, 2'd0);
        @(negedge clk);
        sb_check();
        check("reset_mid.commit", 32'(commit), 32'd0);
        en = 1'b0;
        reset = 1'b0;
        sb_push("idle_after_reset", 24'h000000, 1'b0, 2'd0);
        repeat (3) @(negedge clk);
        sb_check();
        check("idle_after_reset.commit", 32'(commit), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
